// File: rtl/mdu_core.sv
// Multiply/divide unit with architectural HI/LO registers and a fixed-latency busy window.
// Results are computed at launch, held in temp registers and committed when the countdown expires.
module mdu_core #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n;
  logic [31:0]      hi_n, lo_n, thi, tlo, thi_n, tlo_n;

  logic        is_mdu;
  logic        b_zero;
  logic        div_ovf;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvs_s, dvs_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign is_mdu  = (op >= OP_MULT) && (op <= OP_DIVU);
  assign b_zero  = (B == 32'd0);
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, where A/1 gives the wrapped quotient.
  assign dvs_s  = (b_zero || div_ovf) ? 32'd1 : B;
  assign dvs_u  = b_zero ? 32'd1 : B;
  assign quot_s = $signed(A) / $signed(dvs_s);
  assign rem_s  = $signed(A) % $signed(dvs_s);
  assign quot_u = A / dvs_u;
  assign rem_u  = A % dvs_u;

  assign stall = busy | (start & is_mdu);

  always_comb begin
    out = 32'd0;
    if (op == OP_MFHI)      out = HI;
    else if (op == OP_MFLO) out = LO;
  end

  // Next-state: countdown/commit while busy, otherwise launch or move-to-HI/LO.
  always_comb begin
    busy_n = busy;
    cnt_n  = cnt;
    hi_n   = HI;
    lo_n   = LO;
    thi_n  = thi;
    tlo_n  = tlo;
    if (busy) begin
      if (cnt == CNT_W'(1)) begin
        hi_n   = thi;
        lo_n   = tlo;
        busy_n = 1'b0;
        cnt_n  = '0;
      end else begin
        cnt_n = cnt - CNT_W'(1);
      end
    end else if (start && is_mdu) begin
      busy_n = 1'b1;
      case (op)
        OP_MULT: begin
          {thi_n, tlo_n} = prod_s;
          cnt_n          = CNT_W'(MULT_LAT);
        end
        OP_MULTU: begin
          {thi_n, tlo_n} = prod_u;
          cnt_n          = CNT_W'(MULT_LAT);
        end
        OP_DIV: begin
          thi_n = b_zero ? HI : rem_s;
          tlo_n = b_zero ? LO : quot_s;
          cnt_n = CNT_W'(DIV_LAT);
        end
        default: begin
          thi_n = b_zero ? HI : rem_u;
          tlo_n = b_zero ? LO : quot_u;
          cnt_n = CNT_W'(DIV_LAT);
        end
      endcase
    end else if (op == OP_MTHI) begin
      hi_n = A;
    end else if (op == OP_MTLO) begin
      lo_n = A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      HI   <= 32'd0;
      LO   <= 32'd0;
      thi  <= 32'd0;
      tlo  <= 32'd0;
    end else begin
      busy <= busy_n;
      cnt  <= cnt_n;
      HI   <= hi_n;
      LO   <= lo_n;
      thi  <= thi_n;
      tlo  <= tlo_n;
    end
  end

endmodule
